// File: rtl/cdu_read_ctrl.sv
// cdu_read_ctrl: sequencing controller for the CDU summing-amplifier tracking loop.
// Holds the 16-bit read counter, drives the fine ladder switches and the coarse
// sector code, samples the coarse/fine Schmitt-trigger outputs and steps the
// counter toward null with a settle wait after every step.
// Optional feature: define CDU_READ_PULSE_EN to add the _PCDU/_MCDU count-pulse
// outputs and the pending-count stall logic.
module cdu_read_ctrl #(
  parameter int SETTLE_CYCLES = 8,
  parameter int LOCK_COUNT    = 4
`ifdef CDU_READ_PULSE_EN
  ,
  parameter int PULSE_DIV     = 2
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       _CDUZ,
  input  logic       _ENAB,
  input  logic       _TLF2H,
  input  logic       _TLF1H,
  input  logic       _ERRPOS,
  output logic       _D15,
  output logic       _D16,
  output logic       _D17,
  output logic       _D18,
  output logic       _D19,
  output logic       _D20,
  output logic       _D21,
  output logic [8:0] SECTOR,
  output logic [15:0] ANGLE,
  output logic       LOCKED,
  output logic       BUSY
`ifdef CDU_READ_PULSE_EN
  ,
  output logic       _PCDU,
  output logic       _MCDU
`endif
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD =
    (SETTLE_CYCLES > 0) ? SETTLE_W'(SETTLE_CYCLES - 1) : '0;
  localparam int NULL_W = (LOCK_COUNT > 0) ? $clog2(LOCK_COUNT + 1) : 1;
  localparam logic [NULL_W-1:0] LOCK_MAX = NULL_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    SAMPLE = 2'd0,
    STEP   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t              state;
  logic [15:0]         ang;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [NULL_W-1:0]   null_cnt;
  logic                step_coarse;
  logic                step_pos;
  logic                locked;
  logic                stall;
  logic [15:0]         step_mag;

  // Null counter increment that saturates at the lock threshold
  function automatic logic [NULL_W-1:0] sat_inc(input logic [NULL_W-1:0] v);
    return (v == LOCK_MAX) ? v : v + NULL_W'(1);
  endfunction

  assign step_mag = step_coarse ? 16'd128 : 16'd1;

  // Tracking FSM: sample errors, step the counter, wait for the amplifiers to settle
  always_ff @(posedge clk) begin
    if (rst || _CDUZ) begin
      ang        <= '0;
      state      <= SAMPLE;
      settle_cnt <= '0;
      null_cnt   <= '0;
      locked     <= 1'b0;
    end else begin
      case (state)
        SAMPLE: begin
          if (!_ENAB) begin
            null_cnt <= '0;
            locked   <= 1'b0;
          end else if (_TLF2H || _TLF1H) begin
            // Coarse error wins when both comparators fire
            if (!stall) begin
              step_coarse <= _TLF2H;
              step_pos    <= _ERRPOS;
              state       <= STEP;
              locked      <= 1'b0;
            end
          end else begin
            null_cnt <= sat_inc(null_cnt);
            locked   <= (sat_inc(null_cnt) == LOCK_MAX);
          end
        end
        STEP: begin
          ang      <= step_pos ? (ang + step_mag) : (ang - step_mag);
          null_cnt <= '0;
          locked   <= 1'b0;
          if (SETTLE_CYCLES == 0) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          // Error inputs and _ENAB are ignored until the wait completes
          if (settle_cnt == '0) state <= SAMPLE;
          else                  settle_cnt <= settle_cnt - SETTLE_W'(1);
        end
        default: state <= SAMPLE;
      endcase
    end
  end

`ifdef CDU_READ_PULSE_EN
  localparam int DIV_W = (PULSE_DIV > 1) ? $clog2(PULSE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = (PULSE_DIV > 0) ? DIV_W'(PULSE_DIV - 1) : '0;

  logic signed [9:0]  pending;
  logic signed [9:0]  step_amt;
  logic signed [9:0]  req_amt;
  logic signed [9:0]  pulse_amt;
  logic signed [10:0] req_sum;
  logic [DIV_W-1:0]   div_cnt;
  logic               pulse_now;

  assign step_amt  = step_coarse ? (step_pos ? 10'sd128 : -10'sd128)
                                 : (step_pos ? 10'sd1   : -10'sd1);
  assign req_amt   = _TLF2H ? (_ERRPOS ? 10'sd128 : -10'sd128)
                            : (_ERRPOS ? 10'sd1   : -10'sd1);
  assign req_sum   = {pending[9], pending} + {req_amt[9], req_amt};
  // Hold off a step whose count would overflow the pulse backlog
  assign stall     = (state == SAMPLE) && _ENAB && (_TLF2H || _TLF1H) &&
                     ((req_sum > 11'sd255) || (req_sum < -11'sd255));
  assign pulse_now = (pending != 10'sd0) && (div_cnt == '0);
  assign pulse_amt = pulse_now ? (pending[9] ? -10'sd1 : 10'sd1) : 10'sd0;

  // Pending-count accumulator and rate-limited count pulse generator
  always_ff @(posedge clk) begin
    if (rst || _CDUZ) begin
      pending <= '0;
      div_cnt <= '0;
      _PCDU   <= 1'b0;
      _MCDU   <= 1'b0;
    end else begin
      pending <= pending + ((state == STEP) ? step_amt : 10'sd0) - pulse_amt;
      _PCDU   <= pulse_now && !pending[9];
      _MCDU   <= pulse_now && pending[9];
      if (pulse_now)           div_cnt <= DIV_LOAD;
      else if (div_cnt != '0)  div_cnt <= div_cnt - DIV_W'(1);
    end
  end
`else
  assign stall = 1'b0;
`endif

  assign BUSY   = (state != SAMPLE) || stall;
  assign LOCKED = locked;
  assign ANGLE  = ang;
  assign SECTOR = ang[15:7];
  assign _D15   = ~ang[6];
  assign _D16   = ~ang[5];
  assign _D17   = ~ang[4];
  assign _D18   = ~ang[3];
  assign _D19   = ~ang[2];
  assign _D20   = ~ang[1];
  assign _D21   = ~ang[0];

endmodule

// File: tb/tb_cdu_read_ctrl.sv
// tb_cdu_read_ctrl: directed and randomized bench for cdu_read_ctrl with a
// behavioural angle/latency model. Define CDU_READ_PULSE_EN to also exercise
// the count-pulse outputs.
module tb_cdu_read_ctrl;

  localparam int SETTLE_CYCLES = 8;
  localparam int LOCK_COUNT    = 4;
  localparam int PULSE_DIV     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cduz = 1'b0;
  logic        enab = 1'b0;
  logic        tlf2h = 1'b0;
  logic        tlf1h = 1'b0;
  logic        errpos = 1'b0;
  logic        d15, d16, d17, d18, d19, d20, d21;
  logic [8:0]  sector;
  logic [15:0] angle;
  logic        locked;
  logic        busy;
  logic [6:0]  dvec;

  int tests = 0;
  int fails = 0;
  int model_ang = 0;
  int net = 0;

`ifdef CDU_READ_PULSE_EN
  logic pcdu, mcdu;
  int   pcnt = 0;
  int   mcnt = 0;
  int   cyc = 0;
  int   last_pulse = -1;
  int   min_gap = 100000;
`endif

  assign dvec = {d15, d16, d17, d18, d19, d20, d21};

  cdu_read_ctrl #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .LOCK_COUNT   (LOCK_COUNT)
`ifdef CDU_READ_PULSE_EN
    ,
    .PULSE_DIV    (PULSE_DIV)
`endif
  ) dut (
    .clk    (clk),
    .rst    (rst),
    ._CDUZ  (cduz),
    ._ENAB  (enab),
    ._TLF2H (tlf2h),
    ._TLF1H (tlf1h),
    ._ERRPOS(errpos),
    ._D15   (d15),
    ._D16   (d16),
    ._D17   (d17),
    ._D18   (d18),
    ._D19   (d19),
    ._D20   (d20),
    ._D21   (d21),
    .SECTOR (sector),
    .ANGLE  (angle),
    .LOCKED (locked),
    .BUSY   (busy)
`ifdef CDU_READ_PULSE_EN
    ,
    ._PCDU  (pcdu),
    ._MCDU  (mcdu)
`endif
  );

  always #5 clk = ~clk;

`ifdef CDU_READ_PULSE_EN
  always @(negedge clk) begin
    cyc++;
    if (pcdu) pcnt++;
    if (mcdu) mcnt++;
    if (pcdu || mcdu) begin
      if (last_pulse >= 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
      last_pulse = cyc;
    end
  end

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((pcnt - mcnt) != net && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, pcnt - mcnt, net);
  endtask

  task automatic clear_pulse_counts();
    pcnt = 0;
    mcnt = 0;
    net = 0;
    last_pulse = -1;
    min_gap = 100000;
  endtask
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    check({tag, "_angle"}, angle, model_ang);
    check({tag, "_sector"}, sector, model_ang / 128);
    check({tag, "_ladder"}, dvec, (~model_ang) & 32'h7F);
  endtask

  task automatic drop_inputs();
    enab = 1'b0;
    tlf2h = 1'b0;
    tlf1h = 1'b0;
    errpos = 1'b0;
  endtask

  // One sample window: present inputs for one clock, then measure the busy run
  task automatic sample_step(input string tag, input bit e, input bit c, input bit f, input bit p);
    int n;
    int delta;
    bit b0;
`ifdef CDU_READ_PULSE_EN
    drain({tag, "_drain"});
`endif
    @(negedge clk);
    enab = e; tlf2h = c; tlf1h = f; errpos = p;
    @(negedge clk);
    b0 = busy;
    drop_inputs();
    n = 0;
    if (b0) begin
      n = 1;
      @(negedge clk);
      while (busy === 1'b1 && n < 200) begin
        n++;
        @(negedge clk);
      end
    end
    delta = (e && (c || f)) ? (c ? 128 : 1) : 0;
    if (!p) delta = -delta;
    model_ang = (model_ang + delta + 65536) % 65536;
    net += delta;
    check({tag, "_busy_len"}, n, (delta != 0) ? 1 + SETTLE_CYCLES : 0);
    check_out(tag);
    check({tag, "_locked"}, locked, 0);
  endtask

  task automatic zero_cmd();
    @(negedge clk);
    cduz = 1'b1;
    @(negedge clk);
    cduz = 1'b0;
    model_ang = 0;
`ifdef CDU_READ_PULSE_EN
    clear_pulse_counts();
`endif
  endtask

  initial begin
    int n;
    // Reset held for two clocks
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_out("reset");
    check("reset_locked", locked, 0);
    check("reset_busy", busy, 0);
`ifdef CDU_READ_PULSE_EN
    clear_pulse_counts();
`endif

    // Single positive fine step
    sample_step("fine", 1'b1, 1'b0, 1'b1, 1'b1);
    check("fine_d21", d21, 0);

    // Zero command brings the counter back to 0
    zero_cmd();
    check_out("zero");

    // Coarse wins over fine, negative step wraps below zero
    sample_step("coarse_wrap", 1'b1, 1'b1, 1'b1, 1'b0);
    check("coarse_wrap_sector", sector, 9'h1FF);

    // Lock after LOCK_COUNT null samples, drop on the next step
    @(negedge clk);
    enab = 1'b1;
    for (int k = 1; k <= LOCK_COUNT + 1; k++) begin
      @(negedge clk);
      check("lock_seq", locked, (k >= LOCK_COUNT) ? 1 : 0);
    end
    tlf1h = 1'b1;
    errpos = 1'b1;
    @(negedge clk);
    check("lock_drop", locked, 0);
    check("lock_step_busy", busy, 1);
    drop_inputs();
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("lock_settle_len", n, 1 + SETTLE_CYCLES);
    model_ang = (model_ang + 1) % 65536;
    net += 1;
    check_out("lock");

    // Walk to 0x1233, then step to 0x1234 and zero it while settling
    zero_cmd();
    for (int i = 0; i < 36; i++) sample_step("walk_c", 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 51; i++) sample_step("walk_f", 1'b1, 1'b0, 1'b1, 1'b1);
`ifdef CDU_READ_PULSE_EN
    drain("walk_drain");
`endif
    @(negedge clk);
    enab = 1'b1; tlf1h = 1'b1; errpos = 1'b1;
    @(negedge clk);
    drop_inputs();
    @(negedge clk);
    check("mid_settle_angle", angle, 16'h1234);
    check("mid_settle_busy", busy, 1);
    cduz = 1'b1;
    @(negedge clk);
    cduz = 1'b0;
    model_ang = 0;
`ifdef CDU_READ_PULSE_EN
    clear_pulse_counts();
`endif
    check_out("cduz_settle");
    check("cduz_settle_busy", busy, 0);
    check("cduz_settle_locked", locked, 0);

    // Randomized sample windows against the model
    for (int i = 0; i < 40; i++) begin
      sample_step("rand", ($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

`ifdef CDU_READ_PULSE_EN
    // Three held coarse +128 steps: the third must wait for the backlog
    drain("pulse_pre_drain");
    zero_cmd();
    @(negedge clk);
    enab = 1'b1; tlf2h = 1'b1; errpos = 1'b1;
    n = 0;
    while (angle !== 16'h0180 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    drop_inputs();
    check("pulse_third_step", angle, 16'h0180);
    check("pulse_stall_room", (pcnt >= 129) ? 1 : 0, 1);
    model_ang = 16'h0180;
    net = 384;
    drain("pulse_total_drain");
    check("pulse_pcdu_total", pcnt, 384);
    check("pulse_mcdu_total", mcnt, 0);
    check("pulse_spacing", (min_gap >= PULSE_DIV) ? 1 : 0, 1);
    check_out("pulse");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
